mc_ctrl_fsm: RTL and testbench
==============================

// Module: mc_ctrl_fsm
// PURPOSE
//  Multi-cycle control FSM sequencing the shared CPU datapath (single memory port, one ALU, GPR file).
//  Decodes opcode/funct from the IR and drives per-state datapath enables and muxes.
//  Supports addu, subu, jr, ori, lw, sw, beq, lui and jal.
//  Handshakes with memory on a req/ready pair, bounds each memory wait with a timeout, and traps illegal instructions.
// PARAMETERS
//  WAIT_W     8    width of the memory-wait counter
//  MAX_WAIT   255  max cycles mem_req may stay unanswered before a timeout trap (must fit in WAIT_W)
// PORTS
//  clk        in   1  clock, rising edge
//  rst_n      in   1  asynchronous, active-low reset
//  opcode     in   6  IR[31:26]; stable from DECODE until the next FETCH
//  funct      in   6  IR[5:0]
//  zero       in   1  ALU result == 0
//  mem_ready  in   1  memory completes the access this cycle
//  mem_req    out  1  memory access request
//  mem_we     out  1  store (valid only with mem_req)
//  ir_we      out  1  load IR from memory read data
//  pc_we      out  1  PC write enable
//  pc_src     out  2  0 PC+4, 1 branch target, 2 jump target, 3 GPR[rs]
//  reg_we     out  1  GPR write enable
//  reg_dst    out  2  0 rt, 1 rd, 2 $31
//  wd_sel     out  2  0 ALUOut, 1 MDR, 2 PC
//  alu_src_b  out  1  0 GPR[rt], 1 extended immediate
//  ext_op     out  1  0 zero-extend, 1 sign-extend
//  alu_op     out  2  0 ADD, 1 SUB, 2 OR, 3 LUI (imm<<16)
//  retire     out  1  one-cycle pulse when an instruction completes
//  state      out  3  current state encoding
//  illegal    out  1  sticky: illegal instruction trap
//  timeout    out  1  sticky: memory wait exceeded MAX_WAIT
// BEHAVIOUR
//  - States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7. Outputs are a combinational function of state, opcode, funct and zero.
//  - Reset: asynchronous to FETCH. The wait counter, illegal and timeout clear to 0. All enables are 0 except mem_req, which is 1 in FETCH.
//  - Unlisted outputs are 0 in every state.
//  - FETCH: mem_req=1.
//      On mem_ready: ir_we=1, pc_we=1, pc_src=0, then go to DECODE.
//      Otherwise stay in FETCH.
//  - DECODE:
//      jal: pc_we, pc_src=2, reg_we, reg_dst=2, wd_sel=2 (writes the already-incremented PC), retire; go to FETCH.
//      R-type with funct 001000 (jr): pc_we, pc_src=3, retire; go to FETCH.
//      addu (100001), subu (100011), ori, lw, sw, beq, lui: go to EXEC.
//      Any other opcode or funct: go to TRAP.
//  - EXEC:
//      addu: alu_op=ADD, alu_src_b=0. subu: alu_op=SUB, alu_src_b=0.
//      ori: alu_op=OR, alu_src_b=1, ext_op=0. lui: alu_op=LUI, alu_src_b=1.
//      lw/sw: alu_op=ADD, alu_src_b=1, ext_op=1.
//      beq: alu_op=SUB, alu_src_b=0, ext_op=1, pc_src=1, pc_we=zero, retire.
//      Next state: beq to FETCH; lw/sw to MEM; others to WB.
//  - MEM: mem_req=1, mem_we=(sw).
//      On mem_ready: sw asserts retire and goes to FETCH; lw goes to WB.
//  - WB: reg_we=1, retire.
//      R-type: reg_dst=1, wd_sel=0. ori/lui: reg_dst=0, wd_sel=0. lw: reg_dst=0, wd_sel=1.
//      Next state: FETCH.
//  - Wait counter:
//      Clears on entry to FETCH/MEM and whenever mem_ready=1.
//      Increments each cycle mem_req=1 with mem_ready=0, saturating at MAX_WAIT.
//      Reaching MAX_WAIT with mem_ready still 0 sets timeout and goes to TRAP on the next edge.
//      mem_ready in that same cycle takes priority: normal completion, no trap.
//  - TRAP: all enables 0, mem_req=0, state held. Exit only via rst_n. illegal or timeout stays 1.
//  - Latency with zero-wait memory (mem_ready=1 in the first cycle):
//      jal/jr 2, beq 3, sw 4, R/ori/lui 4, lw 5 cycles.
//  - Exactly one retire per completed instruction. No retire in TRAP.
//  - rst_n low mid-instruction aborts immediately. No partial write is issued once reset is asserted.
// TESTING
//  - Reset: rst_n=0 then released, mem_ready=1 -> state=0, mem_req=1, ir_we=1 and pc_we=1 on the first edge; illegal=0, timeout=0.
//  - lw (opcode 100011), zero-wait memory -> states 0,1,2,3,4; WB shows reg_we=1, wd_sel=1; retire only in cycle 5.
//  - beq with zero=1 then zero=0 -> EXEC pc_we=1 / pc_we=0, pc_src=1 both times; 3 cycles each.
//  - FETCH with mem_ready low for 3 cycles then high -> mem_req held 4 cycles, ir_we only in cycle 4.
//  - MAX_WAIT=4, mem_ready never asserted -> timeout=1, state=7 after 5 cycles; all enables 0 thereafter.
//  - opcode 000000 / funct 100000 -> TRAP, illegal=1, no retire. jal -> reg_dst=2, wd_sel=2, pc_src=2 in DECODE, retire.

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle control FSM for the shared single-memory-port CPU datapath.
// Sequences fetch/decode/execute/memory/writeback and traps illegal opcodes and memory timeouts.
//
//   state  | meaning
//   FETCH  | request instruction word; on ready load IR and PC+4
//   DECODE | classify IR; jal/jr complete here
//   EXEC   | ALU operation; beq completes here
//   MEM    | data access for lw/sw; sw completes on ready
//   WB     | GPR write for R-type, ori, lui, lw
//   TRAP   | illegal instruction or memory timeout; left only by reset
module mc_ctrl_fsm #(
  parameter int WAIT_W   = 8,
  parameter int MAX_WAIT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       reg_we,
  output logic [1:0] reg_dst,
  output logic [1:0] wd_sel,
  output logic       alu_src_b,
  output logic       ext_op,
  output logic [1:0] alu_op,
  output logic       retire,
  output logic [2:0] state,
  output logic       illegal,
  output logic       timeout
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;

  localparam logic [1:0] PC_SEQ = 2'd0, PC_BR = 2'd1, PC_JMP = 2'd2, PC_REG = 2'd3;
  localparam logic [1:0] DST_RT = 2'd0, DST_RD = 2'd1, DST_RA = 2'd2;
  localparam logic [1:0] WD_ALU = 2'd0, WD_MDR = 2'd1, WD_PC = 2'd2;
  localparam logic [1:0] ALU_ADD = 2'd0, ALU_SUB = 2'd1, ALU_OR = 2'd2, ALU_LUI = 2'd3;

  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  state_t            st;
  logic [WAIT_W-1:0] wait_cnt;

  logic is_rtype, is_addu, is_subu, is_jr, is_ori, is_lui;
  logic is_lw, is_sw, is_beq, is_jal, goes_exec, wait_expired;

  assign is_rtype  = (opcode == OP_RTYPE);
  assign is_addu   = is_rtype && (funct == FN_ADDU);
  assign is_subu   = is_rtype && (funct == FN_SUBU);
  assign is_jr     = is_rtype && (funct == FN_JR);
  assign is_ori    = (opcode == OP_ORI);
  assign is_lui    = (opcode == OP_LUI);
  assign is_lw     = (opcode == OP_LW);
  assign is_sw     = (opcode == OP_SW);
  assign is_beq    = (opcode == OP_BEQ);
  assign is_jal    = (opcode == OP_JAL);
  assign goes_exec = is_addu || is_subu || is_ori || is_lui || is_lw || is_sw || is_beq;

  // mem_ready in the expiring cycle still completes the access normally
  assign wait_expired = !mem_ready && (wait_cnt == WAIT_MAX);

  assign state = st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= S_FETCH;
      wait_cnt <= '0;
      illegal  <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      case (st)
        S_FETCH: begin
          if (mem_ready) begin
            st       <= S_DECODE;
            wait_cnt <= '0;
          end else if (wait_expired) begin
            st       <= S_TRAP;
            timeout  <= 1'b1;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_DECODE: begin
          wait_cnt <= '0;
          if (is_jal || is_jr) begin
            st <= S_FETCH;
          end else if (goes_exec) begin
            st <= S_EXEC;
          end else begin
            st      <= S_TRAP;
            illegal <= 1'b1;
          end
        end
        S_EXEC: begin
          wait_cnt <= '0;
          if (is_beq)             st <= S_FETCH;
          else if (is_lw || is_sw) st <= S_MEM;
          else                    st <= S_WB;
        end
        S_MEM: begin
          if (mem_ready) begin
            st       <= is_lw ? S_WB : S_FETCH;
            wait_cnt <= '0;
          end else if (wait_expired) begin
            st       <= S_TRAP;
            timeout  <= 1'b1;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_WB: begin
          wait_cnt <= '0;
          st       <= S_FETCH;
        end
        S_TRAP: begin
          wait_cnt <= '0;
        end
        default: begin
          wait_cnt <= '0;
          st       <= S_TRAP;
        end
      endcase
    end
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = PC_SEQ;
    reg_we    = 1'b0;
    reg_dst   = DST_RT;
    wd_sel    = WD_ALU;
    alu_src_b = 1'b0;
    ext_op    = 1'b0;
    alu_op    = ALU_ADD;
    retire    = 1'b0;
    case (st)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we = 1'b1;
          pc_we = 1'b1;
        end
      end
      S_DECODE: begin
        if (is_jal) begin
          pc_we   = 1'b1;
          pc_src  = PC_JMP;
          reg_we  = 1'b1;
          reg_dst = DST_RA;
          wd_sel  = WD_PC;
          retire  = 1'b1;
        end else if (is_jr) begin
          pc_we  = 1'b1;
          pc_src = PC_REG;
          retire = 1'b1;
        end
      end
      S_EXEC: begin
        if (is_subu) begin
          alu_op = ALU_SUB;
        end else if (is_ori) begin
          alu_op    = ALU_OR;
          alu_src_b = 1'b1;
        end else if (is_lui) begin
          alu_op    = ALU_LUI;
          alu_src_b = 1'b1;
        end else if (is_lw || is_sw) begin
          alu_src_b = 1'b1;
          ext_op    = 1'b1;
        end else if (is_beq) begin
          alu_op = ALU_SUB;
          ext_op = 1'b1;
          pc_src = PC_BR;
          pc_we  = zero;
          retire = 1'b1;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = is_sw;
        retire  = is_sw && mem_ready;
      end
      S_WB: begin
        reg_we  = 1'b1;
        retire  = 1'b1;
        reg_dst = is_rtype ? DST_RD : DST_RT;
        wd_sel  = is_lw ? WD_MDR : WD_ALU;
      end
      default: ;
    endcase
    // While reset is held no architectural write may escape, even if memory answers
    if (!rst_n) begin
      mem_we = 1'b0;
      ir_we  = 1'b0;
      pc_we  = 1'b0;
      reg_we = 1'b0;
      retire = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: each instruction is expanded into its expected cycle-by-cycle
// control trace from the instruction rules, then played against the DUT with random memory waits.
module tb_mc_ctrl_fsm;

  localparam int MAXW = 4;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       ir_we;
    logic       pc_we;
    logic [1:0] pc_src;
    logic       reg_we;
    logic [1:0] reg_dst;
    logic [1:0] wd_sel;
    logic       alu_src_b;
    logic       ext_op;
    logic [1:0] alu_op;
    logic       retire;
  } ctrl_t;

  typedef struct packed {
    logic [2:0] st;
    ctrl_t      c;
    logic       rdy;
    logic       z;
    logic       ill;
    logic       to;
  } cyc_t;

  typedef enum int {K_ADDU, K_SUBU, K_JR, K_ORI, K_LW, K_SW, K_BEQ, K_LUI, K_JAL, K_ILL} kind_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, mem_we, ir_we, pc_we, reg_we, alu_src_b, ext_op, retire;
  logic [1:0] pc_src, reg_dst, wd_sel, alu_op;
  logic [2:0] state;
  logic       illegal, timeout;

  ctrl_t obs_c;
  assign obs_c = {mem_req, mem_we, ir_we, pc_we, pc_src, reg_we, reg_dst, wd_sel,
                  alu_src_b, ext_op, alu_op, retire};

  int   n_chk = 0;
  int   n_bad = 0;
  cyc_t q[$];

  mc_ctrl_fsm #(.WAIT_W(8), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we),
    .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we), .reg_dst(reg_dst),
    .wd_sel(wd_sel), .alu_src_b(alu_src_b), .ext_op(ext_op), .alu_op(alu_op),
    .retire(retire), .state(state), .illegal(illegal), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [2:0] st, input ctrl_t c, input logic rdy,
                      input logic ill, input logic to);
    cyc_t e;
    e.st = st; e.c = c; e.rdy = rdy; e.z = 1'($urandom); e.ill = ill; e.to = to;
    q.push_back(e);
  endtask

  task automatic push_trap(input logic ill, input logic to);
    for (int i = 0; i < 3; i++) push(3'd7, '0, 1'($urandom), ill, to);
  endtask

  // w cycles without ready; more than MAXW of them means a timeout trap
  task automatic push_wait(input logic [2:0] st, input ctrl_t c, input int w, output bit trapped);
    int n = (w > MAXW) ? MAXW + 1 : w;
    for (int i = 0; i < n; i++) push(st, c, 1'b0, 1'b0, 1'b0);
    trapped = (w > MAXW);
    if (trapped) push_trap(1'b0, 1'b1);
  endtask

  task automatic build(input kind_t k, input int fw, input int mw, input logic zb, output bit trapped);
    logic [11:0] ill_tab [4];
    ctrl_t c;
    bit    tr;
    ill_tab = '{{6'b000000, 6'b100000}, {6'b000000, 6'b000000},
                {6'b000010, 6'b000000}, {6'b100000, 6'b000011}};
    funct = 6'($urandom);
    case (k)
      K_ADDU: begin opcode = 6'b000000; funct = 6'b100001; end
      K_SUBU: begin opcode = 6'b000000; funct = 6'b100011; end
      K_JR:   begin opcode = 6'b000000; funct = 6'b001000; end
      K_ORI:  opcode = 6'b001101;
      K_LW:   opcode = 6'b100011;
      K_SW:   opcode = 6'b101011;
      K_BEQ:  opcode = 6'b000100;
      K_LUI:  opcode = 6'b001111;
      K_JAL:  opcode = 6'b000011;
      default: {opcode, funct} = ill_tab[$urandom_range(0, 3)];
    endcase
    trapped = 1'b0;
    c = '0; c.mem_req = 1'b1;
    push_wait(3'd0, c, fw, tr);
    if (tr) begin trapped = 1'b1; return; end
    c.ir_we = 1'b1; c.pc_we = 1'b1;
    push(3'd0, c, 1'b1, 1'b0, 1'b0);

    c = '0;
    if (k == K_JAL) begin
      c.pc_we = 1'b1; c.pc_src = 2'd2; c.reg_we = 1'b1; c.reg_dst = 2'd2;
      c.wd_sel = 2'd2; c.retire = 1'b1;
    end else if (k == K_JR) begin
      c.pc_we = 1'b1; c.pc_src = 2'd3; c.retire = 1'b1;
    end
    push(3'd1, c, 1'($urandom), 1'b0, 1'b0);
    if (k == K_JAL || k == K_JR) return;
    if (k == K_ILL) begin push_trap(1'b1, 1'b0); trapped = 1'b1; return; end

    c = '0;
    case (k)
      K_SUBU: c.alu_op = 2'd1;
      K_ORI:  begin c.alu_op = 2'd2; c.alu_src_b = 1'b1; end
      K_LUI:  begin c.alu_op = 2'd3; c.alu_src_b = 1'b1; end
      K_LW, K_SW: begin c.alu_src_b = 1'b1; c.ext_op = 1'b1; end
      K_BEQ:  begin c.alu_op = 2'd1; c.ext_op = 1'b1; c.pc_src = 2'd1; c.pc_we = zb; c.retire = 1'b1; end
      default: ;
    endcase
    push(3'd2, c, 1'($urandom), 1'b0, 1'b0);
    q[q.size()-1].z = zb;
    if (k == K_BEQ) return;

    if (k == K_LW || k == K_SW) begin
      c = '0; c.mem_req = 1'b1; c.mem_we = (k == K_SW);
      push_wait(3'd3, c, mw, tr);
      if (tr) begin trapped = 1'b1; return; end
      c.retire = (k == K_SW);
      push(3'd3, c, 1'b1, 1'b0, 1'b0);
      if (k == K_SW) return;
    end

    c = '0; c.reg_we = 1'b1; c.retire = 1'b1;
    c.reg_dst = (k == K_ADDU || k == K_SUBU) ? 2'd1 : 2'd0;
    c.wd_sel  = (k == K_LW) ? 2'd1 : 2'd0;
    push(3'd4, c, 1'($urandom), 1'b0, 1'b0);
  endtask

  // Called at a falling edge; returns at a falling edge
  task automatic play(input string name, input int upto);
    int n = (upto < 0 || upto > q.size()) ? q.size() : upto;
    for (int i = 0; i < n; i++) begin
      mem_ready = q[i].rdy;
      zero      = q[i].z;
      #1;
      chk($sformatf("%s[%0d].state", name, i), 32'(state), 32'(q[i].st));
      chk($sformatf("%s[%0d].ctrl", name, i), 32'(obs_c), 32'(q[i].c));
      chk($sformatf("%s[%0d].illegal", name, i), 32'(illegal), 32'(q[i].ill));
      chk($sformatf("%s[%0d].timeout", name, i), 32'(timeout), 32'(q[i].to));
      @(negedge clk);
    end
    q.delete();
  endtask

  task automatic do_reset();
    ctrl_t c;
    c = '0; c.mem_req = 1'b1;
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #1;
    chk("rst.state", 32'(state), 32'd0);
    chk("rst.ctrl", 32'(obs_c), 32'(c));
    chk("rst.illegal", 32'(illegal), 32'd0);
    chk("rst.timeout", 32'(timeout), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run(input kind_t k, input int fw, input int mw, input logic zb);
    bit tr;
    build(k, fw, mw, zb, tr);
    play(k.name(), -1);
    if (tr) do_reset();
  endtask

  function automatic int pick_wait();
    int r = $urandom_range(0, 19);
    if (r < 10) return 0;
    if (r < 17) return $urandom_range(1, MAXW);
    if (r < 18) return MAXW;
    return MAXW + 1;
  endfunction

  initial begin
    bit tr;
    do_reset();
    run(K_LW, 0, 0, 1'b0);
    run(K_BEQ, 0, 0, 1'b1);
    run(K_BEQ, 0, 0, 1'b0);
    run(K_ADDU, 3, 0, 1'b0);
    run(K_JAL, 0, 0, 1'b0);
    run(K_SW, MAXW, MAXW, 1'b0);
    run(K_ILL, 0, 0, 1'b0);
    run(K_ADDU, MAXW + 1, 0, 1'b0);
    run(K_LW, 0, MAXW + 1, 1'b0);
    // reset while lw sits in WB with reg_we high
    build(K_LW, 0, 0, 1'b0, tr);
    play("abort", 4);
    do_reset();
    for (int i = 0; i < 150; i++)
      run(kind_t'($urandom_range(0, 9)), pick_wait(), pick_wait(), 1'($urandom));
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
